serial_receiver: RTL and testbench
==================================

# serial_receiver

- Deserializes the single-wire frame format driven by the serial sender: idle-low line, one high start bit, 40 data bits MSB first, then at least one low guard bit.
- Sits at the link input and presents each received 40-bit word on a valid/ready holding register to the downstream command decoder.
- Counterpart of the sender's `data_loss` behaviour: reports overrun when a word arrives while the previous one is still unconsumed.
- Reports framing errors and re-hunts for an idle line after reset or error.

## Interface

Parameters:
- `DATA_WIDTH`, default 40: payload bits per frame.
- `SYNC_STAGES`, default 2: synchronizer flops on `sin`; minimum 2.

Ports:
- `clk`  in  1: single clock, shared with the sender domain rate.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `sin`  in  1: serial line input, asynchronous to `clk` phase.
- `out_data`  out  DATA_WIDTH: held received word.
- `out_valid`  out  1: `out_data` holds an unconsumed word.
- `out_ready`  in  1: consumer accepts the word on a cycle where `out_valid && out_ready`.
- `data_loss`  out  1: one-cycle pulse; a completed word was dropped.
- `frame_error`  out  1: one-cycle pulse; the guard bit sampled high.

## Operation

- `sin` passes through a `SYNC_STAGES` flop chain, reset to 0. The FSM sees only the synced bit `s`.
- HUNT (entered on reset and after a frame error):
  - Counts consecutive `s==0` cycles and clears the count on `s==1`.
  - Goes to IDLE when the count reaches DATA_WIDTH+1.
- IDLE: on `s==1` (start bit) go to DATA and clear the bit counter.
- DATA:
  - Each cycle: shift register `<= {shreg[DATA_WIDTH-2:0], s}`, counter +1.
  - After DATA_WIDTH bits are captured, go to GUARD.
- GUARD, with `s==0`: deliver the word and go to IDLE.
- GUARD, with `s==1`: pulse `frame_error`, discard the word, go to HUNT.
- Delivery:
  - If `out_valid==0`, or `out_ready==1` in the same cycle: load `out_data` and set `out_valid`.
  - Otherwise: keep the old word, drop the new one, and pulse `data_loss`.
- Handshake: `out_valid && out_ready` with no delivery in that cycle clears `out_valid`. `out_data` is unchanged when consumed.
- Counter width is `$clog2(DATA_WIDTH+2)` bits and must not wrap during HUNT (saturate at the threshold).

## Timing

- Reset values: `out_data` = 0, `out_valid` = 0, `data_loss` = 0, `frame_error` = 0, synchronizer = 0, state = HUNT, counters = 0.
- Reset asserted mid-frame aborts the frame, which is never delivered. After release, HUNT requires DATA_WIDTH+1 consecutive lows, so the frame tail cannot cause a false start.
- Let edge `e` be the edge at which the first sync flop captures the start bit:
  - IDLE→DATA at edge `e+SYNC_STAGES`.
  - Data bit `i` (i=1..DATA_WIDTH) captured at edge `e+SYNC_STAGES+i`.
  - Guard bit evaluated at edge `e+SYNC_STAGES+DATA_WIDTH+1`.
  - `out_valid`, `data_loss` and `frame_error` are registered at that edge. With defaults this is `e+43`.
- Back-to-back: a start bit captured at edge `e+DATA_WIDTH+2` (one guard cycle only) is accepted.
- `data_loss` and `frame_error` are high for exactly one cycle per event and never high in the same cycle.
- `out_ready` is a plain level input, with no combinational path to any output.

## Structure

- Shared package `nextasic_serial_pkg` holds:
  - `FRAME_DATA_BITS` = 40, `START_LEVEL` = 1, `IDLE_LEVEL` = 0.
  - The receiver state enum (HUNT, IDLE, DATA, GUARD).
  - The sender uses the same constants.
- One sub-module, `bit_sync`: an N-stage synchronizer with async active-low reset and a `STAGES` parameter.

## Test plan

- Reset, then hold `sin` low for 50 cycles. Send frame `40'hD999999991` with `out_ready=1` → `out_valid` rises at `e+43`, `out_data=40'hD999999991`, no error pulses.
- Two frames `40'hD999999993` and `40'hD999999997` with a single guard cycle, `out_ready=1` → both delivered in order, 42 cycles apart.
- `out_ready=0` while three frames arrive → `out_data` stays at the first word, `data_loss` pulses twice. Then `out_ready=1` for one cycle → `out_valid` falls.
- Delivery of a second word in the same cycle as `out_ready=1` on the first → second word loaded, `out_valid` stays 1, no `data_loss`.
- Frame with guard bit forced high → `frame_error` pulse, no delivery. A start bit sent within 40 lows is ignored; a frame after 41 lows is received.
- Assert `rst_n` low at data bit 20, release, then send the frame tail → all outputs 0 during reset, no delivery or error. The next clean frame is received.

Source files
------------

// File: rtl/nextasic_serial_pkg.sv
// Shared constants and state encoding for the serial link sender/receiver pair.
package nextasic_serial_pkg;

  localparam int   FRAME_DATA_BITS = 40;
  localparam logic START_LEVEL     = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b0;

  // Receiver framing state: HUNT waits for a long idle run, IDLE waits for a
  // start bit, DATA shifts payload bits, GUARD checks the trailing low bit.
  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    IDLE  = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// N-stage flop synchronizer for a single asynchronous bit; resets to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; only the last flop is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Serial link receiver: hunts for an idle line, deframes start + payload +
// guard, and presents each word in a valid/ready holding register.
module serial_receiver
  import nextasic_serial_pkg::*;
#(
  parameter int DATA_WIDTH  = FRAME_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sin,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  data_loss,
  output logic                  frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  // Low count already seen when the final required idle bit arrives.
  localparam logic [CNT_W-1:0] HUNT_LAST = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] HUNT_DONE = CNT_W'(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  s;
  rx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  deliver;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sin),
    .q     (s)
  );

  // A complete, well-framed word is available this cycle.
  assign deliver = (state == GUARD) && (s == IDLE_LEVEL);

  // Framing FSM: idle hunt, start detection, payload shift, guard check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      cnt         <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        HUNT: begin
          if (s == IDLE_LEVEL) begin
            // Saturate so a long idle line can never wrap back to zero.
            if (cnt != HUNT_DONE) cnt <= cnt + 1'b1;
            if (cnt >= HUNT_LAST) state <= IDLE;
          end else begin
            cnt <= '0;
          end
        end
        IDLE: begin
          if (s == START_LEVEL) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          shreg <= {shreg[DATA_WIDTH-2:0], s};
          cnt   <= cnt + 1'b1;
          if (cnt == DATA_LAST) state <= GUARD;
        end
        GUARD: begin
          if (s == IDLE_LEVEL) begin
            state <= IDLE;
          end else begin
            frame_error <= 1'b1;
            state       <= HUNT;
            cnt         <= '0;
          end
        end
        default: begin
          state <= HUNT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output holding register. Handshake: out_valid means out_data holds a word
  // not yet taken; the consumer takes it on any edge where out_valid and
  // out_ready are both high. A new word may replace one being taken on the
  // same edge; a new word arriving while the held one is not being taken is
  // dropped and flagged with a one-cycle data_loss pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      data_loss <= 1'b0;
    end else begin
      data_loss <= 1'b0;
      if (deliver) begin
        if (!out_valid || out_ready) begin
          out_data  <= shreg;
          out_valid <= 1'b1;
        end else begin
          data_loss <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: a bit-stream reference model predicts every
// output cycle; each scenario task adds its own timing and payload checks.
module tb_serial_receiver;

  localparam int DW   = 40;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + DW + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sin = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          data_loss;
  logic          frame_error;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_loss   (data_loss),
    .frame_error (frame_error)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  bit stream_q[$];

  // ---------------- reference model ----------------
  // Works on the history of synchronised line samples: a line is "armed"
  // once the last DW+1 samples are all low, a high sample on an armed line
  // starts a frame, and the sample DW+1 after the start is the guard.
  logic [SYNC-1:0] m_sync = '0;
  bit              s_hist[$];
  int              frame_start = -1;
  bit              armed = 1'b0;
  logic            m_valid = 1'b0, m_loss = 1'b0, m_err = 1'b0, m_load = 1'b0;
  logic [DW-1:0]   m_data = '0, m_word = '0;
  bit              s_now, all_low, got_word;
  int              k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync = '0;
      s_hist.delete();
      frame_start = -1;
      armed = 1'b0;
      m_valid = 1'b0; m_loss = 1'b0; m_err = 1'b0; m_load = 1'b0;
      m_data = '0;
    end else begin
      s_now = m_sync[SYNC-1];
      m_sync = {m_sync[SYNC-2:0], sin};
      s_hist.push_back(s_now);
      k = s_hist.size() - 1;
      got_word = 1'b0; m_loss = 1'b0; m_err = 1'b0; m_load = 1'b0;
      if (frame_start >= 0) begin
        if (k == frame_start + DW + 1) begin
          if (!s_now) begin
            for (int i = 0; i < DW; i++) m_word[DW-1-i] = s_hist[frame_start+1+i];
            got_word = 1'b1;
            armed = 1'b1;
          end else begin
            m_err = 1'b1;
            armed = 1'b0;
          end
          frame_start = -1;
        end
      end else if (armed) begin
        if (s_now) frame_start = k;
      end else if (s_hist.size() >= DW + 1) begin
        all_low = 1'b1;
        for (int i = 0; i <= DW; i++) if (s_hist[k-i]) all_low = 1'b0;
        armed = all_low;
      end
      if (got_word) begin
        if (!m_valid || out_ready) begin
          m_data = m_word; m_valid = 1'b1; m_load = 1'b1;
        end else begin
          m_loss = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand40();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) stream_q.push_back(1'b0);
  endtask

  task automatic add_frame(input logic [DW-1:0] w, input bit guard_hi);
    stream_q.push_back(1'b1);
    for (int i = DW - 1; i >= 0; i--) stream_q.push_back(w[i]);
    stream_q.push_back(guard_hi);
  endtask

  // Present one line bit, let the next edge capture it, sample 1ns later.
  task automatic drive_bit(input bit b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; sin = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) rst_n = 1'b1;
      checks++;
      if ({out_valid, data_loss, frame_error} !== 3'b000 || out_data !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got v=%b l=%b e=%b d=%h, want all zero",
                 out_valid, data_loss, frame_error, out_data);
      end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] w = 40'hD999999991;
    logic [DW-1:0] w_exp;
    int p, e;
    out_ready = 1'b1;
    add_idle(50); p = stream_q.size(); add_frame(w, 1'b0); add_idle(5);
    e = cyc + 1 + p;
    exp_q.push_back(w);
    while (stream_q.size() > 0) begin
      drive_bit(stream_q.pop_front());
      checks++;
      if ({out_valid, data_loss, frame_error, out_data} !== {m_valid, m_loss, m_err, m_data}) begin
        errors++;
        $display("FAIL single_model cyc=%0d: got v%b l%b e%b d=%h, want v%b l%b e%b d=%h",
                 cyc, out_valid, data_loss, frame_error, out_data, m_valid, m_loss, m_err, m_data);
      end
      if (m_load) begin
        checks++;
        w_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== w_exp) begin
          errors++; $display("FAIL single_word: got %h, want %h", out_data, w_exp);
        end
      end
      if (cyc == e + LAT - 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL single_early: out_valid=%b one edge before latency, want 0", out_valid);
        end
      end
      if (cyc == e + LAT) begin
        checks++;
        if ({out_valid, data_loss, frame_error} !== 3'b100 || out_data !== w) begin
          errors++;
          $display("FAIL single_latency: got v%b l%b e%b d=%h, want v1 l0 e0 d=%h",
                   out_valid, data_loss, frame_error, out_data, w);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL single_pending: %0d words never delivered, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] wa = 40'hD999999993, wb = 40'hD999999997;
    logic [DW-1:0] w_exp;
    int p, e1, e2;
    out_ready = 1'b1;
    add_idle(3); p = stream_q.size();
    add_frame(wa, 1'b0); add_frame(wb, 1'b0); add_idle(5);
    e1 = cyc + 1 + p; e2 = e1 + DW + 2;
    exp_q.push_back(wa); exp_q.push_back(wb);
    while (stream_q.size() > 0) begin
      drive_bit(stream_q.pop_front());
      checks++;
      if ({out_valid, data_loss, frame_error, out_data} !== {m_valid, m_loss, m_err, m_data}) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d: got v%b l%b e%b d=%h, want v%b l%b e%b d=%h",
                 cyc, out_valid, data_loss, frame_error, out_data, m_valid, m_loss, m_err, m_data);
      end
      if (m_load) begin
        checks++;
        w_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== w_exp) begin
          errors++; $display("FAIL b2b_word: got %h, want %h", out_data, w_exp);
        end
      end
      if (cyc == e1 + LAT || cyc == e2 + LAT) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ((cyc == e1 + LAT) ? wa : wb)) begin
          errors++;
          $display("FAIL b2b_timing cyc=%0d: got v%b d=%h, want v1 d=%h",
                   cyc, out_valid, out_data, (cyc == e1 + LAT) ? wa : wb);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_pending: %0d words never delivered, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] w0 = rand40(), w1 = rand40(), w2 = rand40();
    int loss_n = 0;
    out_ready = 1'b0;
    add_frame(w0, 1'b0); add_frame(w1, 1'b0); add_frame(w2, 1'b0); add_idle(8);
    while (stream_q.size() > 0) begin
      drive_bit(stream_q.pop_front());
      checks++;
      if ({out_valid, data_loss, frame_error, out_data} !== {m_valid, m_loss, m_err, m_data}) begin
        errors++;
        $display("FAIL overrun_model cyc=%0d: got v%b l%b e%b d=%h, want v%b l%b e%b d=%h",
                 cyc, out_valid, data_loss, frame_error, out_data, m_valid, m_loss, m_err, m_data);
      end
      if (data_loss === 1'b1) loss_n++;
    end
    checks++;
    if (loss_n != 2) begin
      errors++; $display("FAIL overrun_loss_count: got %0d pulses, want 2", loss_n);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== w0) begin
      errors++; $display("FAIL overrun_hold: got v%b d=%h, want v1 d=%h", out_valid, out_data, w0);
    end
    out_ready = 1'b1;
    drive_bit(1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== w0) begin
      errors++; $display("FAIL overrun_drain: got v%b d=%h, want v0 d=%h", out_valid, out_data, w0);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] w0 = rand40(), w1 = rand40();
    logic [DW-1:0] w_exp;
    int p, e1, loss_n = 0;
    out_ready = 1'b0;
    add_idle(2); p = stream_q.size();
    add_frame(w0, 1'b0); add_frame(w1, 1'b0); add_idle(4);
    e1 = cyc + 1 + p + DW + 2;
    exp_q.push_back(w0); exp_q.push_back(w1);
    while (stream_q.size() > 0) begin
      out_ready = (cyc + 1 == e1 + LAT);
      drive_bit(stream_q.pop_front());
      checks++;
      if ({out_valid, data_loss, frame_error, out_data} !== {m_valid, m_loss, m_err, m_data}) begin
        errors++;
        $display("FAIL same_model cyc=%0d: got v%b l%b e%b d=%h, want v%b l%b e%b d=%h",
                 cyc, out_valid, data_loss, frame_error, out_data, m_valid, m_loss, m_err, m_data);
      end
      if (m_load) begin
        checks++;
        w_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== w_exp) begin
          errors++; $display("FAIL same_word: got %h, want %h", out_data, w_exp);
        end
      end
      if (data_loss === 1'b1) loss_n++;
      if (cyc == e1 + LAT) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== w1) begin
          errors++; $display("FAIL same_replace: got v%b d=%h, want v1 d=%h", out_valid, out_data, w1);
        end
      end
    end
    checks++;
    if (loss_n != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL same_loss: got %0d pulses, %0d undelivered, want 0 and 0", loss_n, exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
    drive_bit(1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL same_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_frame_error();
    logic [DW-1:0] wbad = rand40(), wign = 40'hD999999991, wgood = rand40();
    logic [DW-1:0] w_exp;
    int pb, pg, eb, eg, err_n = 0, v_n = 0;
    out_ready = 1'b1;
    add_idle(5); pb = stream_q.size(); add_frame(wbad, 1'b1);
    add_idle(40); add_frame(wign, 1'b0);
    add_idle(41); pg = stream_q.size(); add_frame(wgood, 1'b0); add_idle(5);
    eb = cyc + 1 + pb; eg = cyc + 1 + pg;
    exp_q.push_back(wgood);
    while (stream_q.size() > 0) begin
      drive_bit(stream_q.pop_front());
      checks++;
      if ({out_valid, data_loss, frame_error, out_data} !== {m_valid, m_loss, m_err, m_data}) begin
        errors++;
        $display("FAIL ferr_model cyc=%0d: got v%b l%b e%b d=%h, want v%b l%b e%b d=%h",
                 cyc, out_valid, data_loss, frame_error, out_data, m_valid, m_loss, m_err, m_data);
      end
      if (m_load) begin
        checks++;
        w_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== w_exp) begin
          errors++; $display("FAIL ferr_word: got %h, want %h", out_data, w_exp);
        end
      end
      if (frame_error === 1'b1) err_n++;
      if (out_valid === 1'b1) v_n++;
      if (cyc == eb + LAT) begin
        checks++;
        if (frame_error !== 1'b1 || out_valid !== 1'b0) begin
          errors++; $display("FAIL ferr_pulse: got e%b v%b, want e1 v0", frame_error, out_valid);
        end
      end
      if (cyc == eg + LAT) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== wgood) begin
          errors++; $display("FAIL ferr_recover: got v%b d=%h, want v1 d=%h", out_valid, out_data, wgood);
        end
      end
    end
    checks++;
    if (err_n != 1 || v_n != 1) begin
      errors++; $display("FAIL ferr_counts: got %0d errors %0d valid cycles, want 1 and 1", err_n, v_n);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w = 40'hD999999991, wc = rand40();
    logic [DW-1:0] w_exp;
    int p0, pc, ec, idx = 0, v_n = 0, err_n = 0;
    out_ready = 1'b1;
    add_idle(5); p0 = stream_q.size(); add_frame(w, 1'b0);
    add_idle(50); pc = stream_q.size(); add_frame(wc, 1'b0); add_idle(5);
    ec = cyc + 1 + pc;
    exp_q.push_back(wc);
    while (stream_q.size() > 0) begin
      drive_bit(stream_q.pop_front());
      if (idx == p0 + 20) begin rst_n = 1'b0; #1; end
      if (idx == p0 + 23) rst_n = 1'b1;
      if (!rst_n) begin
        checks++;
        if ({out_valid, data_loss, frame_error} !== 3'b000 || out_data !== '0) begin
          errors++;
          $display("FAIL midreset_zero: got v%b l%b e%b d=%h, want all zero",
                   out_valid, data_loss, frame_error, out_data);
        end
      end
      checks++;
      if ({out_valid, data_loss, frame_error, out_data} !== {m_valid, m_loss, m_err, m_data}) begin
        errors++;
        $display("FAIL midreset_model cyc=%0d: got v%b l%b e%b d=%h, want v%b l%b e%b d=%h",
                 cyc, out_valid, data_loss, frame_error, out_data, m_valid, m_loss, m_err, m_data);
      end
      if (m_load) begin
        checks++;
        w_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== w_exp) begin
          errors++; $display("FAIL midreset_word: got %h, want %h", out_data, w_exp);
        end
      end
      if (out_valid === 1'b1) v_n++;
      if (frame_error === 1'b1 || data_loss === 1'b1) err_n++;
      if (cyc == ec + LAT) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== wc) begin
          errors++; $display("FAIL midreset_clean: got v%b d=%h, want v1 d=%h", out_valid, out_data, wc);
        end
      end
      idx++;
    end
    checks++;
    if (v_n != 1 || err_n != 0) begin
      errors++; $display("FAIL midreset_counts: got %0d valid cycles %0d pulses, want 1 and 0", v_n, err_n);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int frames = 10, loads = 0, loss_n = 0;
    add_idle(3);
    for (int f = 0; f < frames; f++) begin
      add_frame(rand40(), 1'b0);
      add_idle($urandom_range(0, 3));
    end
    add_idle(6);
    while (stream_q.size() > 0) begin
      out_ready = ($urandom_range(0, 1) == 1);
      drive_bit(stream_q.pop_front());
      checks++;
      if ({out_valid, data_loss, frame_error, out_data} !== {m_valid, m_loss, m_err, m_data}) begin
        errors++;
        $display("FAIL random_model cyc=%0d: got v%b l%b e%b d=%h, want v%b l%b e%b d=%h",
                 cyc, out_valid, data_loss, frame_error, out_data, m_valid, m_loss, m_err, m_data);
      end
      if (m_load) loads++;
      if (data_loss === 1'b1) loss_n++;
    end
    checks++;
    if (loads + loss_n != frames) begin
      errors++; $display("FAIL random_accounting: %0d loads + %0d losses, want %0d frames", loads, loss_n, frames);
    end
    out_ready = 1'b1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL random_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_same_cycle();
    test_frame_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
